// File: rtl/beat_hit_judge_pkg.sv
// Shared definitions for the piano-tile hit judge: game state encoding and default widths
// reused by the beat generator and score display.
package beat_hit_judge_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StWin  = 2'd2,
        StFail = 2'd3
    } state_e;

    localparam int unsigned DefBeatW = 7;
    localparam int unsigned DefNoteW = 6;
    localparam int unsigned DefDepth = 96;

endpackage

// File: rtl/beat_hit_judge_chart_ram.sv
// Chart storage: DEPTH x DATA_W registers with async clear, synchronous write and
// combinational read. Out-of-range writes are dropped and out-of-range reads return 0.
module beat_hit_judge_chart_ram #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 6,
    parameter int unsigned DEPTH  = 96
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_ok;
    logic              rd_ok;

    assign wr_ok = wr_en && ({1'b0, wr_addr} < DepthW);
    assign rd_ok = {1'b0, rd_addr} < DepthW;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = rd_ok ? mem_q[rd_addr] : '0;

endmodule

// File: rtl/beat_hit_judge.sv
// Hit-progress checker: counts beats and hits against a loadable cumulative chart and
// judges pass/fail at every beat boundary.
module beat_hit_judge
    import beat_hit_judge_pkg::*;
#(
    parameter int unsigned BEAT_W = DefBeatW,
    parameter int unsigned NOTE_W = DefNoteW,
    parameter int unsigned DEPTH  = DefDepth,
    parameter int unsigned SLACK  = 0,
    parameter int unsigned STRICT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [BEAT_W-1:0] wr_addr,
    input  logic [NOTE_W-1:0] wr_data,
    input  logic [BEAT_W-1:0] song_len,
    input  logic              start,
    input  logic              abort,
    input  logic              beat_tick,
    input  logic              hit_pulse,
    output logic [BEAT_W-1:0] beat_cnt,
    output logic [NOTE_W-1:0] expected,
    output logic [NOTE_W-1:0] hit_cnt,
    output logic              busy,
    output logic              win,
    output logic              fail
);

    localparam logic [BEAT_W:0] DepthW = (BEAT_W + 1)'(DEPTH);
    localparam logic [NOTE_W:0] SlackW = (NOTE_W + 1)'(SLACK);

    state_e            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [NOTE_W-1:0] hit_q, hit_d;
    logic [BEAT_W-1:0] len_q, len_d;

    logic [BEAT_W-1:0] rd_addr;
    logic [NOTE_W-1:0] rd_data;
    logic [BEAT_W-1:0] eff_len;
    logic [NOTE_W:0]   h_ext;
    logic [NOTE_W:0]   e_ext;
    logic              judge_fail;

    beat_hit_judge_chart_ram #(
        .ADDR_W (BEAT_W),
        .DATA_W (NOTE_W),
        .DEPTH  (DEPTH)
    ) u_chart_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en && (state_q != StRun)),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign rd_addr = beat_q - BEAT_W'(1);
    assign eff_len = ({1'b0, song_len} > DepthW) ? DepthW[BEAT_W-1:0] : song_len;

    // Extra bit keeps h + SLACK from wrapping; a same-cycle hit counts toward the closing beat.
    assign h_ext      = {1'b0, hit_q} + {{NOTE_W{1'b0}}, hit_pulse};
    assign e_ext      = {1'b0, rd_data};
    assign judge_fail = ((h_ext + SlackW) < e_ext) || ((STRICT != 0) && (h_ext > e_ext));

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        hit_d   = hit_q;
        len_d   = len_q;
        if (abort) begin
            state_d = StIdle;
            beat_d  = '0;
            hit_d   = '0;
        end else begin
            case (state_q)
                StRun: begin
                    if (hit_pulse && !(&hit_q)) begin
                        hit_d = hit_q + NOTE_W'(1);
                    end
                    if (beat_tick) begin
                        if (judge_fail) begin
                            state_d = StFail;
                        end else if (beat_q == len_q) begin
                            state_d = StWin;
                        end else begin
                            beat_d = beat_q + BEAT_W'(1);
                        end
                    end
                end
                default: begin
                    if (start && (song_len != '0)) begin
                        state_d = StRun;
                        beat_d  = BEAT_W'(1);
                        hit_d   = '0;
                        len_d   = eff_len;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            beat_q  <= '0;
            hit_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            hit_q   <= hit_d;
            len_q   <= len_d;
        end
    end

    assign beat_cnt = beat_q;
    assign expected = (beat_q == '0) ? '0 : rd_data;
    assign hit_cnt  = hit_q;
    assign busy     = (state_q == StRun);
    assign win      = (state_q == StWin);
    assign fail     = (state_q == StFail);

endmodule

// File: doc/beat_hit_judge.md
Name: beat_hit_judge

Overview:
- Next-generation hit-progress checker for the piano tile game.
- Holds a loadable chart of cumulative expected hit counts, indexed by beat, replacing the fixed per-song case table. Each chart value is the number of tiles that must be hit by the end of that beat.
- Tracks beats and player hits, then judges pass/fail at every beat boundary.
- Sits between the beat generator / key debouncers and the display/score logic.

Parameters:
- BEAT_W, 7, width of beat counter and chart address
- NOTE_W, 6, width of cumulative hit counts
- DEPTH, 96, chart entries (beats 1..DEPTH)
- SLACK, 0, hits the player may lag behind the chart without failing
- STRICT, 1, 1 = hitting more than the chart value is a fail; 0 = over-hits are tolerated

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  chart write strobe, honoured only when not in RUN
- wr_addr  in  BEAT_W  chart address (address b-1 holds the value for beat b)
- wr_data  in  NOTE_W  cumulative expected hits
- song_len  in  BEAT_W  beats in the song
- start  in  1  begin or restart a game
- abort  in  1  return to IDLE
- beat_tick  in  1  one-cycle pulse marking the end of the current beat
- hit_pulse  in  1  one-cycle pulse per correct tile hit
- beat_cnt  out  BEAT_W  current beat, 1-based; 0 in IDLE
- expected  out  NOTE_W  chart value for the current beat; 0 when beat_cnt = 0
- hit_cnt  out  NOTE_W  hits so far; saturates at all-ones
- busy  out  1  state == RUN
- win  out  1  state == WIN
- fail  out  1  state == FAIL

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE; beat_cnt = 0, hit_cnt = 0.
  - busy, win, fail all = 0.
  - All chart entries cleared to 0.
- States: IDLE, RUN, WIN, FAIL. State encoding lives in the package.
- IDLE:
  - wr_en writes wr_data to chart[wr_addr] on the next edge.
  - Writes with wr_addr >= DEPTH are dropped.
- Starting a game:
  - start in IDLE, WIN or FAIL → RUN next cycle, with beat_cnt = 1 and hit_cnt = 0.
  - start is ignored when song_len = 0.
  - Effective length L = min(song_len, DEPTH), latched at start.
- RUN:
  - wr_en is ignored.
  - hit_pulse increments hit_cnt (saturating).
  - start while in RUN is ignored.
- Judgement on beat_tick while in RUN, for beat b = beat_cnt:
  - h = hit_cnt + hit_pulse (a same-cycle hit counts toward the closing beat).
  - e = chart[b-1].
  - Fail when h + SLACK < e, or when STRICT = 1 and h > e. → FAIL next cycle; beat_cnt holds b.
  - Otherwise, if b == L → WIN next cycle; beat_cnt holds L.
  - Otherwise beat_cnt = b+1.
  - Latency: verdict visible 1 cycle after the beat_tick edge.
- Comparison widths: do the arithmetic at NOTE_W+1 bits so that h + SLACK cannot wrap.
- expected: combinational read of chart[beat_cnt-1] (registered copy also acceptable if aligned to beat_cnt).
- WIN / FAIL:
  - Counters and outputs hold.
  - beat_tick and hit_pulse are ignored.
  - wr_en is honoured.
- abort in any state → IDLE next cycle; beat_cnt and hit_cnt cleared. abort has priority over start and beat_tick.
- Simultaneous wr_en and start in IDLE: both take effect. The write lands before beat 1 can be judged, because at least one cycle elapses before any beat_tick is processed in RUN.
- Reset mid-game: immediate IDLE, and the chart is lost. Software reloads it.
- Chart values should be non-decreasing. This is not enforced; the block judges whatever is stored.

Decomposition:
- Shared package holds:
  - state encoding: IDLE = 2'd0, RUN = 2'd1, WIN = 2'd2, FAIL = 2'd3
  - default BEAT_W, NOTE_W and DEPTH constants, reused by the beat generator and the score display
- One sub-module, chart_ram:
  - DEPTH x NOTE_W register array
  - async clear, synchronous write, combinational read port

Test Plan:
- Load chart {0,0,1,2}, song_len = 4, STRICT = 1, SLACK = 0. Start; one hit before beat 3's tick, one before beat 4's tick → win = 1 one cycle after the 4th tick; beat_cnt = 4, hit_cnt = 2.
- Same chart, no hits. At the beat-3 tick → fail = 1 next cycle; beat_cnt = 3, hit_cnt = 0.
- Same chart, two hits during beat 1 with STRICT = 1 → fail at the beat-1 tick. With STRICT = 0 the game reaches win.
- SLACK = 1, chart {1,2}, one hit in beat 2 only → beat 1 passes (0+1 ≥ 1), beat 2 passes → win.
- hit_pulse coincident with the beat-3 tick, where chart[2] = 1 and hit_cnt = 0 → passes; hit_cnt = 1 after the edge.
- Abort mid-RUN at beat 2 → IDLE, beat_cnt = 0, hit_cnt = 0. wr_en while in RUN leaves the chart unchanged (verified by restart). Async reset mid-RUN → all outputs 0 and chart reads 0.
